// File: rtl/kanagawa_wide_umul_seq.sv
// kanagawa_wide_umul_seq
// Sequential wide unsigned multiplier. DW-bit operands are cut into 17-bit
// limbs; every limb pair goes through one shared 18x18 DSP multiplier (two
// cycle latency) and the 36-bit partial products are shift-accumulated into a
// 2*DW-bit result. Only one operation is in flight at a time.
//
// _hardware_dsp__umul18 is a behavioural stand-in for the vendor 18x18 DSP
// primitive so the block elaborates on its own.

module _hardware_dsp__umul18 #(
    parameter int    LATENCY       = 2,
    parameter string DEVICE_FAMILY = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_in,
    input  logic [17:0] op_x_in,
    input  logic [17:0] op_y_in,
    output logic [35:0] op_result_out
);

    generate
        if (DEVICE_FAMILY == "") begin : g_generic
            // Multiply first, then carry the product through LATENCY registers.
            logic [35:0] w_product;
            logic [35:0] r_pipe [LATENCY];

            // Operands are only meaningful while op_valid_in is high.
            always_comb begin
                w_product = 36'd0;
                if (op_valid_in) begin
                    w_product = op_x_in * op_y_in;
                end else begin
                    w_product = 36'd0;
                end
            end

            // Product pipeline.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < LATENCY; k++) begin
                        r_pipe[k] <= 36'd0;
                    end
                end else begin
                    r_pipe[0] <= w_product;
                    for (int k = 1; k < LATENCY; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign op_result_out = r_pipe[LATENCY-1];
        end else begin : g_input_reg
            // Hard DSP slices register their inputs; the multiply follows.
            logic [17:0] r_xa;
            logic [17:0] r_ya;
            logic        r_va;
            logic [35:0] r_pipe [LATENCY-1];

            // Input register stage, then product pipeline.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_xa <= 18'd0;
                    r_ya <= 18'd0;
                    r_va <= 1'b0;
                    for (int k = 0; k < LATENCY - 1; k++) begin
                        r_pipe[k] <= 36'd0;
                    end
                end else begin
                    r_xa      <= op_x_in;
                    r_ya      <= op_y_in;
                    r_va      <= op_valid_in;
                    r_pipe[0] <= r_va ? (r_xa * r_ya) : 36'd0;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign op_result_out = r_pipe[LATENCY-2];
        end
    endgenerate

endmodule

module kanagawa_wide_umul_seq #(
    parameter int    DW            = 34,
    parameter string DEVICE_FAMILY = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   x_in,
    input  logic [DW-1:0]   y_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] z_out
);

    localparam int LIMB = 17;
    localparam int N    = DW / LIMB;
    localparam int ZW   = 2 * DW;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam int SW   = $clog2(ZW) + 1;
    localparam int PW   = ZW + 36;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_i;
    logic [CW-1:0]   r_j;
    logic [CW-1:0]   w_i_next;
    logic [CW-1:0]   w_j_next;
    logic            r_drain_cnt;
    logic            w_drain_cnt_next;
    logic            w_load;
    logic            w_issue;

    logic [DW-1:0]   r_x;
    logic [DW-1:0]   r_y;
    logic [ZW-1:0]   r_acc;
    logic [ZW-1:0]   w_addend;

    logic [17:0]     w_op_x;
    logic [17:0]     w_op_y;
    logic [SW-1:0]   w_issue_shift;
    logic [35:0]     w_dsp_result;

    // Tag pipe: stage 1 lines up with the DSP output.
    logic [1:0]      r_tag_valid;
    logic [SW-1:0]   r_tag_shift [2];

    // Next-state, issue-counter and strobe logic.
    always_comb begin
        w_state_next     = r_state;
        w_i_next         = r_i;
        w_j_next         = r_j;
        w_drain_cnt_next = r_drain_cnt;
        w_load           = 1'b0;
        w_issue          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_i_next     = {CW{1'b0}};
                    w_j_next     = {CW{1'b0}};
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (r_j == CW'(N - 1)) begin
                    w_j_next = {CW{1'b0}};
                    if (r_i == CW'(N - 1)) begin
                        w_i_next         = {CW{1'b0}};
                        w_drain_cnt_next = 1'b0;
                        w_state_next     = ST_DRAIN;
                    end else begin
                        w_i_next = r_i + CW'(1);
                    end
                end else begin
                    w_j_next = r_j + CW'(1);
                end
            end
            ST_DRAIN: begin
                // Two cycles let the last product clear the DSP pipeline.
                if (r_drain_cnt) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_drain_cnt_next = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register and issue counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_i         <= {CW{1'b0}};
            r_j         <= {CW{1'b0}};
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_i         <= w_i_next;
            r_j         <= w_j_next;
            r_drain_cnt <= w_drain_cnt_next;
        end
    end

    // Operand capture on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= {DW{1'b0}};
            r_y <= {DW{1'b0}};
        end else if (w_load) begin
            r_x <= x_in;
            r_y <= y_in;
        end else begin
            r_x <= r_x;
            r_y <= r_y;
        end
    end

    // Limb selection for the current (i, j) pair; idle cycles feed zeros.
    always_comb begin
        w_op_x        = 18'd0;
        w_op_y        = 18'd0;
        w_issue_shift = {SW{1'b0}};
        if (w_issue) begin
            w_op_x        = {1'b0, r_x[LIMB*int'(r_i) +: LIMB]};
            w_op_y        = {1'b0, r_y[LIMB*int'(r_j) +: LIMB]};
            w_issue_shift = SW'(LIMB * (int'(r_i) + int'(r_j)));
        end else begin
            w_op_x        = 18'd0;
            w_op_y        = 18'd0;
            w_issue_shift = {SW{1'b0}};
        end
    end

    _hardware_dsp__umul18 #(
        .LATENCY       (2),
        .DEVICE_FAMILY (DEVICE_FAMILY)
    ) u_dsp (
        .clk           (clk),
        .rst           (rst),
        .op_valid_in   (w_issue),
        .op_x_in       (w_op_x),
        .op_y_in       (w_op_y),
        .op_result_out (w_dsp_result)
    );

    // Tag pipe travelling alongside the DSP; reset drops in-flight products.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_valid    <= 2'b00;
            r_tag_shift[0] <= {SW{1'b0}};
            r_tag_shift[1] <= {SW{1'b0}};
        end else begin
            r_tag_valid    <= {r_tag_valid[0], w_issue};
            r_tag_shift[0] <= w_issue_shift;
            r_tag_shift[1] <= r_tag_shift[0];
        end
    end

    // Partial product aligned to its limb weight. The 36-bit product never
    // exceeds 34 significant bits, so truncating to ZW loses nothing.
    always_comb begin
        w_addend = ZW'({{(PW-36){1'b0}}, w_dsp_result} << r_tag_shift[1]);
    end

    // Shift-accumulate; cleared on accept and on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= {ZW{1'b0}};
        end else if (w_load) begin
            r_acc <= {ZW{1'b0}};
        end else if (r_tag_valid[1]) begin
            r_acc <= r_acc + w_addend;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign z_out     = r_acc;

endmodule

// File: tb/tb_kanagawa_wide_umul_seq.sv
// Self-checking bench for kanagawa_wide_umul_seq at DW = 34, 17 and 68.
// Expected products come from plain wide multiplication in the bench.

module tb_kanagawa_wide_umul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DW = 34 instance
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [33:0] a_x, a_y;
    logic [67:0] a_z;
    // DW = 17 instance
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [16:0] b_x, b_y;
    logic [33:0] b_z;
    // DW = 68 instance
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [67:0]  c_x, c_y;
    logic [135:0] c_z;

    int n_cmp = 0;
    int n_bad = 0;

    kanagawa_wide_umul_seq #(.DW(34)) u_dut34 (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .x_in(a_x), .y_in(a_y), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .z_out(a_z)
    );

    kanagawa_wide_umul_seq #(.DW(17)) u_dut17 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x_in(b_x), .y_in(b_y), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .z_out(b_z)
    );

    kanagawa_wide_umul_seq #(.DW(68)) u_dut68 (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .x_in(c_x), .y_in(c_y), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .z_out(c_z)
    );

    task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] rand34();
        return {2'($urandom_range(3)), $urandom()};
    endfunction

    function automatic logic [67:0] rand68();
        if ($urandom_range(9) == 0) return {68{1'b1}};
        return {4'($urandom_range(15)), $urandom(), $urandom()};
    endfunction

    // One DW=34 operation from an idle DUT; hold = cycles of out_ready low.
    task automatic op34(input logic [33:0] x, input logic [33:0] y, input int hold);
        logic [67:0] exp;
        int c;
        bit seen;
        exp = {34'd0, x} * {34'd0, y};
        check_val("a_ready_idle", a_in_ready, 1);
        a_x = x; a_y = y; a_in_valid = 1'b1; a_out_ready = (hold == 0);
        tick();
        a_in_valid = 1'b0;
        a_x = rand34(); a_y = rand34();
        c = 1; seen = 0;
        while (c <= 30 && !seen) begin
            check_val("a_busy_ready", a_in_ready, 0);
            if (a_out_valid) seen = 1;
            else begin tick(); c++; end
        end
        check_val("a_latency", c, 7);
        check_val("a_product", a_z, exp);
        for (int k = 0; k < hold; k++) begin
            check_val("a_hold_z", a_z, exp);
            check_val("a_hold_valid", a_out_valid, 1);
            check_val("a_hold_ready", a_in_ready, 0);
            tick();
        end
        // Handshake cycle: new operands offered simultaneously must not be taken.
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check_val("a_ready_after", a_in_ready, 1);
        check_val("a_valid_after", a_out_valid, 0);
    endtask

    initial begin
        int c;
        int got_n, cyc, acc_cyc;
        bit prev_v;
        logic [135:0] q[$];
        logic [135:0] e;

        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_x = '0; a_y = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b1; c_x = '0; c_y = '0;
        repeat (3) tick();
        check_val("rst_a_ready", a_in_ready, 0);
        check_val("rst_c_ready", c_in_ready, 0);
        check_val("rst_a_valid", a_out_valid, 0);
        check_val("rst_a_z", a_z, 0);
        check_val("rst_c_z", c_z, 0);
        rst = 1'b0;
        #1;
        check_val("post_rst_a_ready", a_in_ready, 1);
        check_val("post_rst_b_ready", b_in_ready, 1);

        // Directed DW=34 cases
        op34(34'h3_FFFF_FFFF, 34'h3_FFFF_FFFF, 0);
        op34(34'h2_0000_0001, 34'h3, 0);
        op34(34'h0, 34'h3_FFFF_FFFF, 0);
        op34(rand34(), rand34(), 10);
        for (int k = 0; k < 4; k++) op34(rand34(), rand34(), 0);

        // Reset in the middle of an operation with products in flight
        a_x = 34'h3_FFFF_FFFF; a_y = 34'h3_FFFF_FFFF; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_val("mid_rst_valid", a_out_valid, 0);
        check_val("mid_rst_ready", a_in_ready, 1);
        check_val("mid_rst_z", a_z, 0);
        op34(34'd5, 34'd7, 0);

        // DW=17, single limb
        b_x = 17'h1FFFF; b_y = 17'h1FFFF; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        c = 1;
        while (c <= 20 && !b_out_valid) begin tick(); c++; end
        check_val("b_latency", c, 4);
        check_val("b_product", b_z, 34'h3_FFFC_0001);
        tick();
        check_val("b_ready_after", b_in_ready, 1);

        // DW=68 random traffic with stalls on both sides
        got_n = 0; cyc = 0; acc_cyc = 0; prev_v = 0;
        while (got_n < 200 && cyc < 20000) begin
            c_in_valid  = ($urandom_range(3) != 0);
            c_out_ready = ($urandom_range(3) != 0);
            c_x = rand68();
            c_y = rand68();
            if (c_in_valid && c_in_ready) begin
                e = {68'd0, c_x} * {68'd0, c_y};
                q.push_back(e);
                acc_cyc = cyc;
            end
            if (c_out_valid && !prev_v) check_val("c_latency", cyc - acc_cyc, 19);
            if (c_out_valid && c_out_ready) begin
                check_val("c_queue", (q.size() > 0), 1);
                if (q.size() > 0) check_val("c_product", c_z, q.pop_front());
                got_n++;
            end
            prev_v = c_out_valid;
            tick();
            cyc++;
        end
        c_in_valid = 1'b0;
        check_val("c_count", got_n, 200);
        check_val("c_leftover", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kanagawa_wide_umul_seq.md
# kanagawa_wide_umul_seq

Sequential wide unsigned multiplier that splits DW-bit operands into 17-bit limbs and feeds the limb pairs, one per cycle, into a single `_hardware_dsp__umul18` instance (LATENCY = 2). It shift-accumulates the returning 36-bit partial products into a 2·DW-bit result. It sits directly upstream of the 18x18 DSP primitive and lets compiler-generated datapaths do multiplies wider than one DSP while spending only one DSP slice.

## Interface
- DW, 34: operand width. Must be a multiple of 17; 17 ≤ DW ≤ 68. N = DW/17 limbs.
- DEVICE_FAMILY, "": passed through to the DSP primitive.
- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept operands.
- x_in  in  DW  multiplicand, unsigned.
- y_in  in  DW  multiplier, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- z_out  out  2·DW  product x·y, unsigned.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready = 1.
  - On in_valid && in_ready, register x_in/y_in, clear the accumulator and the issue counters (i, j), then go to ISSUE.
- ISSUE: one limb pair per cycle.
  - Ordering is i outer, j inner, each 0..N-1.
  - Operands to the DSP: op_x_in = {1'b0, x[17i+16:17i]}, op_y_in = {1'b0, y[17j+16:17j]}; op_valid_in = 1.
  - A 2-deep tag pipe carries (valid, shift = 17·(i+j)) alongside each issue.
  - After issuing (N-1, N-1), go to DRAIN.
- DRAIN: holds for 2 cycles with op_valid_in = 0, then goes to DONE.
- Accumulate: in every cycle where the tag pipe output is valid, acc <= acc + (op_result_out << shift).
  - The accumulator is 2·DW bits. The top bit of each limb product is always 0.
  - Intermediate sums never exceed the final product, so no overflow is possible.
- DONE: out_valid = 1 and z_out = acc, both held stable until out_ready. On out_valid && out_ready, return to IDLE.
- in_ready = 0 in ISSUE, DRAIN and DONE. There is no overlap between operations.
- When op_valid_in = 0, DSP operand inputs are driven with 0.
- Reset (any state, including mid-ISSUE/DRAIN):
  - Next state is IDLE.
  - Tag pipe valids and accumulator are cleared, so in-flight DSP products are discarded.
  - z_out = 0.
- Reset values: in_ready = 0 while rst is high, 1 in the first cycle after rst deasserts. out_valid = 0, z_out = 0.

## Timing
- The accept cycle is cycle 0.
- Issues occur in cycles 1..N².
- A product issued in cycle t appears on op_result_out in cycle t+2 and is accumulated at the end of cycle t+2.
- out_valid first rises in cycle N²+3. For the default N = 2 that is cycle 7.
- With out_ready held high, in_ready returns in cycle N²+4. Peak throughput is one multiply per N²+4 cycles.
- out_ready is registered into the state only. There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.
- in_valid and out_ready asserted in the same DONE cycle: the result is consumed. The new operands are not accepted until the following IDLE cycle.

## Test plan
- Max operands, DW = 34: x = y = 0x3_FFFF_FFFF.
  - Required: z_out = 0xF_FFFF_FFF8_0000_0001.
  - out_valid at cycle 7 after accept; in_ready low in cycles 1–7.
- Cross-limb value: x = 0x2_0000_0001, y = 0x3.
  - Required: z_out = 0x6_0000_0003.
  - Then back-to-back x = 0, y = 0x3_FFFF_FFFF gives z_out = 0. This checks that the accumulator clears between operations.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid.
  - Required: z_out stable, in_ready = 0 throughout.
  - Releasing out_ready gives a one-cycle handshake, then in_ready = 1 in the next cycle.
- Reset mid-operation: assert rst for 1 cycle at cycle 3 of an operation (products in flight).
  - Required: the next cycle is IDLE with out_valid = 0.
  - A following x = 5, y = 7 yields exactly 35; no stale partial products are added.
- DW = 17 (N = 1): x = 0x1FFFF, y = 0x1FFFF.
  - Required: z_out = 0x3_FFFC_0001, out_valid at cycle 4.
- DW = 68 (N = 4): 200 random operand pairs with random in_valid/out_ready stalls.
  - Every z_out matches the reference x·y.
  - Latency is 19 cycles when there are no stalls.
